riscv_boot_loader: RTL and testbench
====================================

// Module: riscv_boot_loader
// PURPOSE
// - Upstream of the single-cycle core: receives a program image as a byte stream and writes
//   32-bit words into the instruction memory write port.
// - Holds the core in reset until a complete, checksum-valid image is loaded, then releases it.
// - Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count N, LE), N x 4 bytes (LE words), CHK
//   (XOR of all 4N payload bytes).
// PARAMETERS
// - IMEM_ADDR_WIDTH  8     word-address width of instruction memory; depth = 2**IMEM_ADDR_WIDTH
// - INST_WIDTH       32    instruction word width; fixed at 4 bytes
// - TIMEOUT_CYCLES   4096  max idle cycles between bytes inside a frame before ERROR
// PORTS
// - i_clk          in   1                single clock, rising edge
// - i_rst          in   1                synchronous, active-high reset
// - i_rx_valid     in   1                byte valid from serial front end
// - i_rx_data      in   8                byte payload
// - o_rx_ready     out  1                byte accepted when i_rx_valid && o_rx_ready
// - i_reload       in   1                1-cycle pulse: abort/restart, re-hold core in reset
// - o_imem_we      out  1                instruction memory write strobe, 1 cycle per word
// - o_imem_addr    out  IMEM_ADDR_WIDTH  word address, 0..N-1
// - o_imem_wdata   out  INST_WIDTH       assembled word
// - o_core_rst_n   out  1                active-low reset to the core
// - o_busy         out  1                frame in progress (states LEN_LO..CHECK)
// - o_done         out  1                image loaded and verified
// - o_err          out  1                sticky error until i_reload or i_rst
// BEHAVIOUR
// - Reset values: state=IDLE, o_rx_ready=1, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0,
//   o_core_rst_n=0, o_busy=0, o_done=0, o_err=0; byte, word, timeout counters and checksum = 0.
// - FSM: IDLE -> LEN_LO -> LEN_HI -> DATA -> CHECK -> DONE; any state -> ERROR on fault.
//   - IDLE: accept bytes; 0xA5 -> LEN_LO, any other byte discarded.
//   - LEN_LO/LEN_HI: latch N. After LEN_HI: N==0 or N>2**IMEM_ADDR_WIDTH -> ERROR, else DATA.
//   - DATA: 2-bit byte counter shifts bytes into the word LSB-first; XOR each byte into checksum.
//     On the 4th byte, register o_imem_wdata and o_imem_addr = word index; pulse o_imem_we on
//     the next cycle (1-cycle latency). Word index then increments. After word N-1 -> CHECK.
//   - CHECK: next byte == checksum -> DONE, else ERROR.
//   - DONE: o_rx_ready=0, o_done=1; o_core_rst_n=1 from the cycle after entering DONE.
//   - ERROR: o_rx_ready=0, o_err=1, o_core_rst_n=0; no further imem writes.
// - o_rx_ready=1 in IDLE..CHECK; no backpressure is needed because one word write takes
//   one cycle and at least 4 byte handshakes separate consecutive writes.
// - Timeout: counter clears on every accepted byte and counts while in LEN_LO..CHECK;
//   reaching TIMEOUT_CYCLES -> ERROR. Not active in IDLE, DONE or ERROR.
// - i_reload (any state): next state IDLE; counters, checksum, o_done and o_err clear;
//   o_core_rst_n=0 in the same cycle as state entry. i_rst has priority over i_reload.
// - A byte offered in the same cycle as i_reload is dropped.
// - A reload mid-frame leaves already-written words in imem; the core stays in reset.
// - Address wrap cannot occur: the N bound check guarantees o_imem_addr <= 2**IMEM_ADDR_WIDTH-1.
// STRUCTURE
// - Package riscv_pkg: boot_state_t enum, BOOT_SYNC_BYTE = 8'hA5.
// - Single module; no sub-module. The timeout counter is inline.
// TESTING
// - 3-word image, back-to-back bytes -> 3 o_imem_we pulses at addr 0,1,2 with correct LE data;
//   o_done=1; o_core_rst_n rises 1 cycle after DONE.
// - Bytes 0x00,0x13 before 0xA5 -> garbage discarded, no writes; frame then loads normally.
// - LEN=0 and LEN=2**IMEM_ADDR_WIDTH+1 -> ERROR right after LEN_HI, zero writes, o_err=1.
// - Image with wrong CHK byte -> all N words written, then o_err=1, o_done=0, o_core_rst_n=0.
// - Gap of TIMEOUT_CYCLES after byte 5 of the frame -> ERROR. Gap of TIMEOUT_CYCLES-1 -> OK.
// - i_reload pulse mid-DATA, then new 1-word frame -> writes addr 0 only, DONE;
//   i_rst mid-frame -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the boot loader: FSM state encoding and the frame sync byte.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/riscv_boot_loader.sv
// Loads a framed program image from a byte stream into instruction memory and holds the
// core in reset until the whole image has arrived with a matching XOR checksum.
module riscv_boot_loader
    import riscv_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int INST_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx_valid,
    input  logic [7:0]                 i_rx_data,
    output logic                       o_rx_ready,
    input  logic                       i_reload,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [INST_WIDTH-1:0]      o_imem_wdata,
    output logic                       o_core_rst_n,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output boot_state_t                o_state
);

    localparam int                 TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]        MAX_WORDS = 17'(2 ** IMEM_ADDR_WIDTH);

    boot_state_t                state, state_next;
    logic [7:0]                 len_lo_q;
    logic [15:0]                len_q;
    logic [1:0]                 byte_cnt;
    logic [IMEM_ADDR_WIDTH-1:0] word_idx;
    logic [INST_WIDTH-9:0]      byte_sr;
    logic [7:0]                 chk_q;
    logic [TCNT_W-1:0]          tcnt;

    logic        accept;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;
    logic        timeout_hit;

    // Byte handshake: a byte transfers on a rising edge where i_rx_valid && o_rx_ready.
    // o_rx_ready depends only on state; a byte offered together with i_reload is dropped.
    assign accept      = i_rx_valid && o_rx_ready && !i_reload;
    assign len_full    = {i_rx_data, len_lo_q};
    assign len_bad     = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
    assign last_word   = (16'(word_idx) == (len_q - 16'd1));
    assign timeout_hit = o_busy && !accept && (tcnt == TCNT_LAST);
    assign o_state     = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_reload) begin
            state_next = ST_IDLE;
        end else if (timeout_hit) begin
            state_next = ST_ERROR;
        end else if (accept) begin
            case (state)
                ST_IDLE:   if (i_rx_data == BOOT_SYNC_BYTE) state_next = ST_LEN_LO;
                ST_LEN_LO: state_next = ST_LEN_HI;
                ST_LEN_HI: state_next = len_bad ? ST_ERROR : ST_DATA;
                ST_DATA:   if (byte_cnt == 2'd3 && last_word) state_next = ST_CHECK;
                ST_CHECK:  state_next = (i_rx_data == chk_q) ? ST_DONE : ST_ERROR;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        o_rx_ready = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        case (state)
            ST_IDLE: o_rx_ready = 1'b1;
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b1;
            end
            ST_DONE:  o_done = 1'b1;
            ST_ERROR: o_err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length latch, LSB-first word assembly, checksum, write strobe, timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            byte_sr      <= '0;
            chk_q        <= '0;
            tcnt         <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_core_rst_n <= 1'b0;
        end else if (i_reload) begin
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            byte_sr      <= '0;
            chk_q        <= '0;
            tcnt         <= '0;
            o_imem_we    <= 1'b0;
            o_core_rst_n <= 1'b0;
        end else begin
            o_imem_we    <= 1'b0;
            // Released one cycle after DONE is entered, so the image write has settled.
            o_core_rst_n <= (state == ST_DONE);
            tcnt         <= (accept || !o_busy) ? '0 : tcnt + TCNT_W'(1);
            if (accept) begin
                case (state)
                    ST_LEN_LO: len_lo_q <= i_rx_data;
                    ST_LEN_HI: len_q    <= len_full;
                    ST_DATA: begin
                        chk_q    <= chk_q ^ i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        byte_sr  <= {i_rx_data, byte_sr[INST_WIDTH-9:8]};
                        if (byte_cnt == 2'd3) begin
                            o_imem_wdata <= {i_rx_data, byte_sr};
                            o_imem_addr  <= word_idx;
                            o_imem_we    <= 1'b1;
                            word_idx     <= word_idx + IMEM_ADDR_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Directed bench for riscv_boot_loader: frames are built from word lists, expected imem
// writes are queued as the frame is sent and matched by a per-cycle compare process.
module tb_riscv_boot_loader;
    import riscv_pkg::*;

    localparam int AW = 8;
    localparam int T  = 4096;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_reload = 1'b0;
    logic          o_rx_ready;
    logic          o_imem_we;
    logic [AW-1:0] o_imem_addr;
    logic [31:0]   o_imem_wdata;
    logic          o_core_rst_n;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    boot_state_t   o_state;

    int          checks = 0;
    int          failures = 0;
    logic        run_cmp = 1'b0;
    logic [39:0] exp_q[$];
    logic [31:0] img[$];

    riscv_boot_loader #(
        .IMEM_ADDR_WIDTH(AW),
        .INST_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_rx_valid(i_rx_valid),
        .i_rx_data(i_rx_data),
        .o_rx_ready(o_rx_ready),
        .i_reload(i_reload),
        .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata),
        .o_core_rst_n(o_core_rst_n),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err),
        .o_state(o_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        chk("rx_ready_in_frame", 64'(o_rx_ready), 64'd1);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(BOOT_SYNC_BYTE);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    // Sends header, first n words of img, checksum (bit 0 flipped if corrupt).
    // Optionally idles gap_len cycles after payload byte gap_idx.
    task automatic send_image(input int n, input logic corrupt, input int gap_idx,
                              input int gap_len);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        int          p;
        x = 8'h00;
        p = 0;
        send_header(16'(n));
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                if (k == 3) exp_q.push_back({8'(i), w});
                send_byte(b);
                x = x ^ b;
                if (p == gap_idx && gap_len > 0) idle(gap_len);
                p++;
            end
        end
        send_byte(x ^ {7'd0, corrupt});
        idle(1);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic core_rst_n);
        chk({tag, "_done"}, 64'(o_done), 64'(done));
        chk({tag, "_err"}, 64'(o_err), 64'(err));
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'(core_rst_n));
        chk({tag, "_rx_ready"}, 64'(o_rx_ready), 64'(!(done || err)));
    endtask

    task automatic check_drained(input string tag);
        #1;
        chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 64'(o_rx_ready), 64'd1);
        chk({tag, "_imem_we"}, 64'(o_imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(o_imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(o_imem_wdata), 64'd0);
        chk({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_err"}, 64'(o_err), 64'd0);
        chk({tag, "_state"}, 64'(o_state), 64'(ST_IDLE));
    endtask

    task automatic do_reload(input string tag);
        @(negedge i_clk);
        i_reload   = 1'b1;
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        i_reload = 1'b0;
        check_status({tag, "_reload"}, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard: every imem write must match the head of the expected queue
    initial begin
        logic [7:0]  ea;
        logic [31:0] ed;
        wait (run_cmp == 1'b1);
        forever begin
            @(negedge i_clk);
            if (o_imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 64'(o_imem_addr), 64'hFFFF);
                end else begin
                    {ea, ed} = exp_q.pop_front();
                    chk("write_addr", 64'(o_imem_addr), 64'(ea));
                    chk("write_data", 64'(o_imem_wdata), 64'(ed));
                end
            end
            if (o_core_rst_n === 1'b1) chk("core_release_needs_done", 64'(o_done), 64'd1);
        end
    end

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_values("reset");
        run_cmp = 1'b1;

        // 3-word image, back-to-back bytes; checksum of these words is 0x82
        img = '{32'h00000013, 32'h00100093, 32'h002081B3};
        send_image(3, 1'b0, -1, 0);
        check_status("img3", 1'b1, 1'b0, 1'b0);
        chk("img3_last_addr", 64'(o_imem_addr), 64'd2);
        chk("img3_last_data", 64'(o_imem_wdata), 64'h002081B3);
        check_drained("img3");
        @(negedge i_clk);
        chk("img3_core_release", 64'(o_core_rst_n), 64'd1);
        do_reload("img3");

        // garbage before sync
        send_byte(8'h00);
        send_byte(8'h13);
        img = '{32'hCAFEF00D, 32'h12345678};
        send_image(2, 1'b0, -1, 0);
        check_status("garbage", 1'b1, 1'b0, 1'b0);
        check_drained("garbage");
        do_reload("garbage");

        // bad lengths
        send_header(16'd0);
        idle(1);
        check_status("len0", 1'b0, 1'b1, 1'b0);
        chk("len0_state", 64'(o_state), 64'(ST_ERROR));
        check_drained("len0");
        do_reload("len0");

        send_header(16'((1 << AW) + 1));
        idle(1);
        check_status("len_over", 1'b0, 1'b1, 1'b0);
        check_drained("len_over");
        do_reload("len_over");

        // wrong checksum: words still written
        img = '{32'hA1B2C3D4, 32'h0F1E2D3C};
        send_image(2, 1'b1, -1, 0);
        check_status("bad_chk", 1'b0, 1'b1, 1'b0);
        check_drained("bad_chk");
        @(negedge i_clk);
        chk("bad_chk_core_held", 64'(o_core_rst_n), 64'd0);
        do_reload("bad_chk");

        // gap of T cycles after frame byte 5 -> timeout
        img = '{32'h11223344, 32'h55667788};
        send_header(16'd2);
        send_byte(8'h44);
        send_byte(8'h33);
        idle(T - 1);
        chk("timeout_not_early", 64'(o_err), 64'd0);
        idle(1);
        @(negedge i_clk);
        check_status("timeout", 1'b0, 1'b1, 1'b0);
        check_drained("timeout");
        do_reload("timeout");

        // gap of T-1 cycles is tolerated
        send_image(2, 1'b0, 1, T - 1);
        check_status("gap_ok", 1'b1, 1'b0, 1'b0);
        check_drained("gap_ok");
        do_reload("gap_ok");

        // maximum image fills every address
        img.delete();
        for (int i = 0; i < (1 << AW); i++) img.push_back(32'(i) * 32'h01030507 + 32'h13);
        send_image(1 << AW, 1'b0, -1, 0);
        check_status("full", 1'b1, 1'b0, 1'b0);
        chk("full_last_addr", 64'(o_imem_addr), 64'd255);
        check_drained("full");
        do_reload("full");

        // reload mid-DATA, byte offered with reload is dropped, then 1-word frame
        img = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        send_header(16'd3);
        exp_q.push_back({8'd0, 32'h01020304});
        send_byte(8'h04);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h08);
        send_byte(8'h07);
        @(negedge i_clk);
        i_reload   = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = BOOT_SYNC_BYTE;
        @(negedge i_clk);
        i_reload   = 1'b0;
        i_rx_valid = 1'b0;
        check_status("mid_reload", 1'b0, 1'b0, 1'b0);
        chk("mid_reload_state", 64'(o_state), 64'(ST_IDLE));
        check_drained("mid_reload");
        img = '{32'hDEADBEEF};
        send_image(1, 1'b0, -1, 0);
        check_status("after_reload", 1'b1, 1'b0, 1'b0);
        chk("after_reload_addr", 64'(o_imem_addr), 64'd0);
        chk("after_reload_data", 64'(o_imem_wdata), 64'hDEADBEEF);
        check_drained("after_reload");
        do_reload("after_reload");

        // synchronous reset mid-frame
        send_header(16'd2);
        exp_q.push_back({8'd0, 32'h89ABCDEF});
        send_byte(8'hEF);
        send_byte(8'hCD);
        send_byte(8'hAB);
        send_byte(8'h89);
        send_byte(8'h77);
        @(negedge i_clk);
        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_values("mid_rst");
        check_drained("mid_rst");
        img = '{32'h00500093};
        send_image(1, 1'b0, -1, 0);
        check_status("after_rst", 1'b1, 1'b0, 1'b0);
        check_drained("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
